start_ctrl_mc: RTL and testbench
================================

Name: start_ctrl_mc

Overview:
- Multi-channel start-pulse controller for the optical synchronizing pulse generator; successor to the single-channel start latch.
- Per channel, asserts a start-enable level from a debounced active-low button or a PC start request, and drops it on that channel's end flag.
- Optionally drops it on a maximum light-pulse duration timeout.
- Sits between the front-panel/PC interface and the pulse sequencers; each st_o bit gates one sequencer.

Parameters:
- CH_NUM, 4, number of independent start channels (1..16)
- DEB_CYC, 1000, cycles the synced button must stay stable (low to arm, high to re-arm); minimum 2
- DEB_W, 16, debounce counter width; must satisfy DEB_CYC < 2**DEB_W
- CNT_W, 41, duration counter width
- MAX_DUR, 41'd100000000, maximum active cycles per start when the timeout is compiled in; minimum 1

Ports:
- st_clk  in  1  system clock
- st_rst_n  in  1  reset, asynchronous, active-low
- st_button  in  CH_NUM  per-channel start button, active-low, asynchronous, bouncy
- pc_start  in  1  PC start request, asynchronous level; its rising edge starts channels
- pc_mask  in  CH_NUM  1 = channel accepts pc_start; quasi-static
- end_flg  in  CH_NUM  per-channel end-of-sequence flag, synchronous to st_clk, level
- st_o  out  CH_NUM  per-channel start enable level
- timeout_o  out  CH_NUM  sticky: last activation was ended by the MAX_DUR limit
- busy_o  out  1  OR of st_o

Behaviour:
- Reset (st_rst_n low, asynchronous): st_o=0, timeout_o=0, busy_o=0, all FSMs to IDLE, all counters 0, sync flops to inactive (button 1, pc 0). Outputs are registered; busy_o is registered and follows st_o in the same cycle.
- Synchronisation:
  - st_button[i] and pc_start each pass through 2-FF synchronisers.
  - pc_start is then edge-detected with one register; pc_rise = synced high AND previous synced low.
- Per-channel FSM:
  - IDLE:
    - Debounce counter counts while the synced button is low; any synced high clears it.
    - When the counter = DEB_CYC-1 with the button still low, go to ACTIVE and set st_o=1.
    - Also go to ACTIVE if pc_rise and pc_mask[i]=1.
    - Entering ACTIVE clears timeout_o[i] and the duration counter.
  - ACTIVE:
    - st_o=1; the duration counter increments each cycle, saturating at all-ones.
    - end_flg[i]=1 -> HOLDOFF with st_o=0 on that edge.
  - HOLDOFF:
    - st_o=0; the debounce counter counts while the synced button is high; any low clears it.
    - Reaching DEB_CYC-1 -> IDLE. pc_rise is ignored in HOLDOFF.
    - This prevents retriggering while the button is held or bouncing on release.
- Latency:
  - Clean button press: st_o rises on edge 2+DEB_CYC after the first edge that samples the button low.
  - pc_start: st_o rises on edge 3 after the first edge that samples pc_start high.
  - end_flg: st_o falls on the first edge that samples end_flg high.
- Simultaneous events:
  - end_flg[i]=1 in the same cycle as a start qualification in IDLE: the channel stays in IDLE, st_o stays 0, and the debounce counter is cleared (end wins).
  - Button start and pc_rise in the same cycle: a single activation.
- Channel independence: channels are fully independent; one pc_rise may start several channels.
- Reset mid-operation: reset while ACTIVE drops st_o immediately, asynchronously.

Optional Feature:
- Macro: START_TIMEOUT_EN.
- Defined:
  - In ACTIVE, when the duration counter = MAX_DUR-1 and end_flg[i]=0, go to HOLDOFF on the next edge with st_o=0 and timeout_o[i]=1.
  - st_o is therefore high for exactly MAX_DUR cycles at most.
  - If end_flg and the limit coincide, end wins and timeout_o stays 0.
- Not defined:
  - No duration limit; timeout_o is tied to 0; the duration counter may be omitted.
  - ACTIVE is left only via end_flg or reset.

Test Plan:
- Reset release, all buttons high, pc_start 0, DEB_CYC=4 -> st_o=0, timeout_o=0, busy_o=0 for 100 cycles.
- Channel 0 button low held 20 cycles, DEB_CYC=4 -> st_o[0] rises on edge 6 after first low sample; other bits stay 0; busy_o=1.
- Channel 1 button glitch low for 3 cycles then high, DEB_CYC=4 -> st_o[1] never rises; a 4-cycle glitch raises it.
- pc_start rises with pc_mask=4'b0101 -> st_o=4'b0101 on edge 3.
  - end_flg[2] pulse 1 cycle -> st_o=4'b0001 on the next edge.
  - A second pc_start rise before the button-high holdoff completes leaves st_o[2]=0.
- end_flg[0] asserted in the same cycle the debounce completes -> st_o[0] stays 0.
- With START_TIMEOUT_EN and MAX_DUR=10, pc start on channel 3 with no end_flg -> st_o[3] high exactly 10 cycles, then timeout_o[3]=1; the next pc start clears timeout_o[3].

Source files
------------

// File: rtl/start_ctrl_mc.sv
`default_nettype none
// start_ctrl_mc: per-channel start-enable controller (debounced button or PC start, stopped by end flag).
// Optional max-duration timeout compiled in with START_TIMEOUT_EN.  Rev 1.0
module start_ctrl_mc #(
  parameter int               CH_NUM  = 4,
  parameter int               DEB_CYC = 1000,
  parameter int               DEB_W   = 16,
  parameter int               CNT_W   = 41,
  parameter logic [CNT_W-1:0] MAX_DUR = 41'd100000000
) (
  input  logic              st_clk,
  input  logic              st_rst_n,
  input  logic [CH_NUM-1:0] st_button,
  input  logic              pc_start,
  input  logic [CH_NUM-1:0] pc_mask,
  input  logic [CH_NUM-1:0] end_flg,
  output logic [CH_NUM-1:0] st_o,
  output logic [CH_NUM-1:0] timeout_o,
  output logic              busy_o
);

  localparam logic [1:0]       c_IDLE     = 2'd0;
  localparam logic [1:0]       c_ACTIVE   = 2'd1;
  localparam logic [1:0]       c_HOLDOFF  = 2'd2;
  localparam logic [DEB_W-1:0] c_DEB_LAST = DEB_W'(DEB_CYC - 1);

  logic [CH_NUM-1:0] r_btn_s1;
  logic [CH_NUM-1:0] r_btn_s2;
  logic              r_pc_s1;
  logic              r_pc_s2;
  logic              r_pc_prev;
  logic              r_busy;
  logic              w_pc_rise;
  logic [CH_NUM-1:0] w_st_nxt;

  // Synchronisers idle at the inactive level: button released, PC request low.
  always_ff @(posedge st_clk or negedge st_rst_n) begin
    if (!st_rst_n) begin
      r_btn_s1  <= '1;
      r_btn_s2  <= '1;
      r_pc_s1   <= 1'b0;
      r_pc_s2   <= 1'b0;
      r_pc_prev <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_btn_s1  <= st_button;
      r_btn_s2  <= r_btn_s1;
      r_pc_s1   <= pc_start;
      r_pc_s2   <= r_pc_s1;
      r_pc_prev <= r_pc_s2;
      r_busy    <= |w_st_nxt;
    end
  end

  assign w_pc_rise = r_pc_s2 & ~r_pc_prev;
  assign busy_o    = r_busy;

`ifndef START_TIMEOUT_EN
  logic w_unused_cfg;
  assign w_unused_cfg = ^MAX_DUR;
`endif

  for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [DEB_W-1:0] r_deb;
    logic [DEB_W-1:0] w_deb_nxt;
    logic             r_st;
    logic             w_st_n;
    logic             w_deb_done;
    logic             w_start;
    logic             w_timeout;

    assign w_deb_done = (r_deb == c_DEB_LAST);
    assign w_start    = (~r_btn_s2[gi] & w_deb_done) | (w_pc_rise & pc_mask[gi]);

`ifdef START_TIMEOUT_EN
    localparam logic [CNT_W-1:0] c_DUR_LAST = MAX_DUR - CNT_W'(1);
    logic [CNT_W-1:0] r_dur;
    logic             r_to;
    logic             w_to_n;

    assign w_timeout = (r_dur == c_DUR_LAST);

    always_ff @(posedge st_clk or negedge st_rst_n) begin
      if (!st_rst_n) begin
        r_dur <= '0;
        r_to  <= 1'b0;
      end else begin
        r_to <= w_to_n;
        if (r_state != c_ACTIVE && w_state_nxt == c_ACTIVE)
          r_dur <= '0;
        else if (r_state == c_ACTIVE && r_dur != {CNT_W{1'b1}})
          r_dur <= r_dur + CNT_W'(1);
      end
    end

    // Sticky flag: set only when the limit (not end_flg) closes the activation.
    always_comb begin
      w_to_n = r_to;
      if (r_state != c_ACTIVE && w_state_nxt == c_ACTIVE)
        w_to_n = 1'b0;
      else if (r_state == c_ACTIVE && w_state_nxt == c_HOLDOFF && !end_flg[gi])
        w_to_n = 1'b1;
    end

    assign timeout_o[gi] = r_to;
`else
    assign w_timeout     = 1'b0;
    assign timeout_o[gi] = 1'b0;
`endif

    always_ff @(posedge st_clk or negedge st_rst_n) begin
      if (!st_rst_n) begin
        r_state <= c_IDLE;
        r_deb   <= '0;
        r_st    <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_deb   <= w_deb_nxt;
        r_st    <= w_st_n;
      end
    end

    always_comb begin
      w_state_nxt = r_state;
      w_deb_nxt   = r_deb;
      case (r_state)
        c_IDLE: begin
          if (w_start) begin
            // A simultaneous end flag vetoes the start and restarts debouncing.
            w_deb_nxt = '0;
            if (!end_flg[gi]) w_state_nxt = c_ACTIVE;
          end else if (r_btn_s2[gi]) begin
            w_deb_nxt = '0;
          end else begin
            w_deb_nxt = r_deb + DEB_W'(1);
          end
        end
        c_ACTIVE: begin
          w_deb_nxt = '0;
          if (end_flg[gi] || w_timeout) w_state_nxt = c_HOLDOFF;
        end
        c_HOLDOFF: begin
          if (!r_btn_s2[gi]) begin
            w_deb_nxt = '0;
          end else if (w_deb_done) begin
            w_deb_nxt   = '0;
            w_state_nxt = c_IDLE;
          end else begin
            w_deb_nxt = r_deb + DEB_W'(1);
          end
        end
        default: begin
          w_deb_nxt   = '0;
          w_state_nxt = c_IDLE;
        end
      endcase
    end

    always_comb begin
      w_st_n = (w_state_nxt == c_ACTIVE);
    end

    assign w_st_nxt[gi] = w_st_n;
    assign st_o[gi]     = r_st;
  end

endmodule
`default_nettype wire

// File: tb/tb_start_ctrl_mc.sv
`default_nettype none
// tb_start_ctrl_mc: directed and random stimulus against a cycle-level behavioural model.
module tb_start_ctrl_mc;
  localparam int CH   = 4;
  localparam int DEB  = 4;
  localparam int MAXD = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CH-1:0] btn;
  logic          pc;
  logic [CH-1:0] mask;
  logic [CH-1:0] endf;
  wire  [CH-1:0] st;
  wire  [CH-1:0] to;
  wire           busy;

  start_ctrl_mc #(
    .CH_NUM (CH),
    .DEB_CYC(DEB),
    .DEB_W  (16),
    .CNT_W  (41),
    .MAX_DUR(41'd10)
  ) dut (
    .st_clk   (clk),
    .st_rst_n (rst_n),
    .st_button(btn),
    .pc_start (pc),
    .pc_mask  (mask),
    .end_flg  (endf),
    .st_o     (st),
    .timeout_o(to),
    .busy_o   (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef enum {READY, LIT, COOLDOWN} phase_t;
  phase_t        ph   [CH];
  int            run  [CH];
  int            lit  [CH];
  logic [CH-1:0] b_d1, b_d2;
  logic          p_d1, p_d2, p_prev;
  logic [CH-1:0] m_st, m_to;

  function automatic void model_reset();
    b_d1 = '1; b_d2 = '1;
    p_d1 = 1'b0; p_d2 = 1'b0; p_prev = 1'b0;
    m_st = '0; m_to = '0;
    for (int c = 0; c < CH; c++) begin
      ph[c] = READY; run[c] = 0; lit[c] = 0;
    end
  endfunction

  // One clock edge: run-length debounce on the synced view, then shift the sync pipes.
  function automatic void model_edge();
    logic [CH-1:0] bs;
    logic          prise;
    bs    = b_d2;
    prise = p_d2 && !p_prev;
    for (int c = 0; c < CH; c++) begin
      case (ph[c])
        READY: begin
          run[c] = bs[c] ? 0 : run[c] + 1;
          if (run[c] >= DEB || (prise && mask[c])) begin
            run[c] = 0;
            if (!endf[c]) begin
              ph[c] = LIT; lit[c] = 1; m_to[c] = 1'b0;
            end
          end
        end
        LIT: begin
          if (endf[c]) begin
            ph[c] = COOLDOWN; run[c] = 0;
          end
`ifdef START_TIMEOUT_EN
          else if (lit[c] >= MAXD) begin
            ph[c] = COOLDOWN; run[c] = 0; m_to[c] = 1'b1;
          end
`endif
          else lit[c] = lit[c] + 1;
        end
        default: begin
          run[c] = bs[c] ? run[c] + 1 : 0;
          if (run[c] >= DEB) begin
            ph[c] = READY; run[c] = 0;
          end
        end
      endcase
      m_st[c] = (ph[c] == LIT);
    end
    p_prev = p_d2; p_d2 = p_d1; p_d1 = pc;
    b_d2 = b_d1; b_d1 = btn;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("st_o", 32'(st), 32'(m_st));
    chk("timeout_o", 32'(to), 32'(m_to));
    chk("busy_o", 32'(busy), 32'(|m_st));
  endtask

  task automatic cycn(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; btn = '1; pc = 1'b0; endf = '0;
    #1;
    model_reset();
    chk("rst_async_st", 32'(st), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_st", 32'(st), 32'd0);
    chk("rst_to", 32'(to), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    int hi;
    rst_n = 1'b1; btn = '1; pc = 1'b0; mask = '0; endf = '0;
    model_reset();
    #2;
    do_reset();
    cycn(100);

    // Clean press on channel 0
    btn[0] = 1'b0;
    cycn(5);
    chk("btn0_before", 32'(st), 32'd0);
    cyc();
    chk("btn0_rise", 32'(st), 32'b0001);
    chk("btn0_busy", 32'(busy), 32'd1);
    cycn(14);
    btn[0] = 1'b1;
    endf[0] = 1'b1; cyc(); endf = '0;
    chk("btn0_end", 32'(st), 32'd0);
    cycn(12);

    // Short and just-long-enough glitches on channel 1
    btn[1] = 1'b0; cycn(3); btn[1] = 1'b1; cycn(8);
    chk("glitch3", 32'(st), 32'd0);
    btn[1] = 1'b0; cycn(4); btn[1] = 1'b1; cycn(4);
    chk("glitch4", 32'(st), 32'b0010);
    endf[1] = 1'b1; cyc(); endf = '0;
    cycn(10);

    // PC start with mask, end on one channel, re-start during its holdoff
    mask = 4'b0101; pc = 1'b1;
    cycn(2);
    chk("pc_edge2", 32'(st), 32'd0);
    cyc();
    chk("pc_edge3", 32'(st), 32'b0101);
    cycn(3);
    pc = 1'b0; cycn(4);
    endf[2] = 1'b1; pc = 1'b1; cyc(); endf = '0;
    chk("end2", 32'(st), 32'b0001);
    cycn(6);
    chk("holdoff_ignore_pc", 32'(st), 32'b0001);
    pc = 1'b0;
    endf[0] = 1'b1; cyc(); endf = '0;
    cycn(12);

    // End flag coincident with debounce completion
    mask = '0;
    btn[0] = 1'b0; cycn(5);
    endf[0] = 1'b1; cyc(); endf = '0;
    chk("end_wins", 32'(st), 32'd0);
    btn[0] = 1'b1;
    cycn(12);

    // Random bouncy buttons, PC toggles, end pulses, one mid-run reset
    for (int k = 0; k < 800; k++) begin
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 9) == 0) btn[c] = ~btn[c];
      if ($urandom_range(0, 14) == 0) pc = ~pc;
      if (k % 100 == 0) mask = CH'($urandom);
      for (int c = 0; c < CH; c++) endf[c] = ($urandom_range(0, 11) == 0);
      if (k == 400) begin
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("midrst_st", 32'(st), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
      end else begin
        cyc();
      end
    end

    // Duration limit on channel 3
    do_reset();
    mask = 4'b1000; pc = 1'b1;
    cycn(3);
    chk("ch3_start", 32'(st), 32'b1000);
    hi = 1;
    for (int k = 0; k < 40; k++) begin
      cyc();
      if (st[3]) hi++;
      else break;
    end
`ifdef START_TIMEOUT_EN
    chk("dur_cycles", 32'(hi), 32'(MAXD));
    chk("timeout_set", 32'(to), 32'b1000);
    pc = 1'b0; cycn(10);
    pc = 1'b1; cycn(3);
    chk("timeout_clr", 32'(to), 32'd0);
    chk("ch3_restart", 32'(st), 32'b1000);
`else
    chk("no_limit", 32'(hi), 32'd41);
    chk("no_timeout", 32'(to), 32'd0);
`endif
    endf[3] = 1'b1; cyc(); endf = '0;
    cycn(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
